// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit LCD interface blocks.
// Holds the state encoding, the register-select values and the default timing constants.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HI_E,
    S_HI_GAP,
    S_LO_E,
    S_LO_GAP,
    S_DONE
  } state_t;

  localparam logic RS_INSTR = 1'b0;
  localparam logic RS_DATA  = 1'b1;

  localparam int unsigned BF_BIT = 7;

  // Timing at 50 MHz
  localparam int unsigned SETUP_CYCLES_DEF   = 3;
  localparam int unsigned EN_HIGH_CYCLES_DEF = 12;
  localparam int unsigned EN_LOW_CYCLES_DEF  = 50;
  localparam int unsigned POLL_LIMIT_DEF     = 1000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that reports done while the count sits at zero.
// A load of N-1 on state entry keeps the caller in that state for exactly N cycles.
module lcd_phase_timer #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780 4-bit read sequencer: fetches the busy/address byte or a data byte,
// optionally repeating busy-flag reads until BF clears or the poll limit is reached.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = SETUP_CYCLES_DEF,
  parameter int unsigned EN_HIGH_CYCLES = EN_HIGH_CYCLES_DEF,
  parameter int unsigned EN_LOW_CYCLES  = EN_LOW_CYCLES_DEF,
  parameter int unsigned POLL_LIMIT     = POLL_LIMIT_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPollBusy,
  input  logic [3:0] iLCD_Data,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic       oData_OE,
  output logic [7:0] oByte,
  output logic       oValid,
  output logic       oTimeout,
  output logic       oBusy
);

  localparam int unsigned TW     = $clog2(max3(SETUP_CYCLES, EN_HIGH_CYCLES, EN_LOW_CYCLES) + 1);
  localparam int unsigned PW_RAW = $clog2(POLL_LIMIT + 1);
  localparam int unsigned PW     = (PW_RAW > 10) ? PW_RAW : 10;

  state_t          state_q, state_d;
  logic            rs_q, rs_d;
  logic            poll_q, poll_d;
  logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [3:0]      hi_q, hi_d;
  logic [3:0]      lo_q, lo_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            tmo_q, tmo_d;
  logic            e_q, e_d;
  logic            lcd_rs_q, lcd_rs_d;
  logic            rw_q, rw_d;
  logic            oe_q, oe_d;
  logic            busy_q, busy_d;

  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_done_c;
  logic [7:0]      rd_byte_c;

  assign rd_byte_c = {hi_q, lo_q};

  function automatic logic [TW-1:0] phase_load(input state_t s);
    case (s)
      S_SETUP:            phase_load = TW'(SETUP_CYCLES - 1);
      S_HI_E, S_LO_E:     phase_load = TW'(EN_HIGH_CYCLES - 1);
      S_HI_GAP, S_LO_GAP: phase_load = TW'(EN_LOW_CYCLES - 1);
      default:            phase_load = '0;
    endcase
  endfunction

  lcd_phase_timer #(.W(TW)) u_timer (
    .clk      (Clock),
    .rst_n    (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done_c   (tmr_done_c)
  );

  // Next state, captures, and pin levels decoded from the state being entered
  always_comb begin
    state_d    = state_q;
    rs_d       = rs_q;
    poll_d     = poll_q;
    poll_cnt_d = poll_cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    data_d     = data_q;
    tmo_d      = tmo_q;
    valid_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          rs_d       = iRS;
          poll_d     = iPollBusy && (iRS != RS_DATA);
          poll_cnt_d = '0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP:  if (tmr_done_c) state_d = S_HI_E;
      S_HI_E: begin
        if (tmr_done_c) begin
          hi_d    = iLCD_Data;
          state_d = S_HI_GAP;
        end
      end
      S_HI_GAP: if (tmr_done_c) state_d = S_LO_E;
      S_LO_E: begin
        if (tmr_done_c) begin
          lo_d    = iLCD_Data;
          state_d = S_LO_GAP;
        end
      end
      S_LO_GAP: begin
        if (tmr_done_c) begin
          if (!poll_q || !rd_byte_c[BF_BIT]) begin
            data_d  = rd_byte_c;
            tmo_d   = 1'b0;
            valid_d = 1'b1;
            state_d = S_DONE;
          end else if (poll_cnt_q < PW'(POLL_LIMIT - 1)) begin
            // Re-read straight away: RS/RW are already settled from the first read
            poll_cnt_d = poll_cnt_q + PW'(1);
            state_d    = S_HI_E;
          end else begin
            data_d  = rd_byte_c;
            tmo_d   = 1'b1;
            valid_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    tmr_load = (state_d != state_q);
    tmr_val  = phase_load(state_d);

    e_d      = (state_d == S_HI_E) || (state_d == S_LO_E);
    rw_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    oe_d     = (state_d == S_IDLE);
    busy_d   = (state_d != S_IDLE);
    lcd_rs_d = (state_d == S_IDLE) ? RS_INSTR : rs_d;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      rs_q       <= RS_INSTR;
      poll_q     <= 1'b0;
      poll_cnt_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      tmo_q      <= 1'b0;
      e_q        <= 1'b0;
      lcd_rs_q   <= 1'b0;
      rw_q       <= 1'b0;
      oe_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      poll_q     <= poll_d;
      poll_cnt_q <= poll_cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      tmo_q      <= tmo_d;
      e_q        <= e_d;
      lcd_rs_q   <= lcd_rs_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
    end
  end

  assign oLCD_E   = e_q;
  assign oLCD_RS  = lcd_rs_q;
  assign oLCD_RW  = rw_q;
  assign oData_OE = oe_q;
  assign oByte    = data_q;
  assign oValid   = valid_q;
  assign oTimeout = tmo_q;
  assign oBusy    = busy_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Scoreboard bench for lcd_reader: an LCD pin model answers E pulses from a byte queue,
// a reference model predicts each transaction's result, and a monitor checks pins and results.
`timescale 1ns/1ps
module tb_lcd_reader;
  import lcd_pkg::*;

  localparam int unsigned PLIM     = 4;
  localparam int          PAIR     = 2 * int'(EN_HIGH_CYCLES_DEF + EN_LOW_CYCLES_DEF);
  // iStart cycle through oValid cycle inclusive for a single read
  localparam int          LAT_BASE = 1 + int'(SETUP_CYCLES_DEF) + PAIR + 1;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] b;
    logic       tmo;
    int         reads;
    logic       rs;
    int         start_cyc;
  } exp_t;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       iStart = 1'b0;
  logic       iRS = 1'b0;
  logic       iPollBusy = 1'b0;
  logic [3:0] lcd_nib = 4'h0;
  logic       oLCD_E, oLCD_RS, oLCD_RW, oData_OE, oValid, oTimeout, oBusy;
  logic [7:0] oByte;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  bq_t  lcd_q;
  logic nib_hi = 1'b1;
  logic [7:0] cur = 8'h00;

  int   rises = 0;
  int   hi_run = 0;
  int   lo_run = 0;
  logic seen_e = 1'b0;
  logic e_prev = 1'b0;
  logic valid_prev = 1'b0;

  lcd_reader #(.POLL_LIMIT(PLIM)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iStart    (iStart),
    .iRS       (iRS),
    .iPollBusy (iPollBusy),
    .iLCD_Data (lcd_nib),
    .oLCD_E    (oLCD_E),
    .oLCD_RS   (oLCD_RS),
    .oLCD_RW   (oLCD_RW),
    .oData_OE  (oData_OE),
    .oByte     (oByte),
    .oValid    (oValid),
    .oTimeout  (oTimeout),
    .oBusy     (oBusy)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // LCD side: each read pair presents the high nibble then the low nibble of the next byte
  always @(oLCD_E) begin
    if (oLCD_E === 1'b1) begin
      if (nib_hi) begin
        cur = (lcd_q.size() != 0) ? lcd_q.pop_front() : 8'($urandom);
        lcd_nib = cur[7:4];
      end else begin
        lcd_nib = cur[3:0];
      end
      nib_hi = !nib_hi;
    end else begin
      #2;
      if (oLCD_E !== 1'b1) lcd_nib = 4'($urandom);
    end
  end

  // Behavioural expectation from the byte sequence the LCD will return
  function automatic void ref_model(input logic rs, input logic poll, input bq_t seq,
                                    output logic [7:0] b, output logic tmo, output int reads);
    b = seq[0]; tmo = 1'b0; reads = 1;
    if (rs == 1'b0 && poll) begin
      for (int i = 0; i < seq.size(); i++) begin
        reads = i + 1;
        b = seq[i];
        if (seq[i][7] == 1'b0) begin tmo = 1'b0; break; end
        if (reads == int'(PLIM)) begin tmo = 1'b1; break; end
      end
    end
  endfunction

  // Monitor: pin protocol every cycle, result compare on each oValid
  always @(negedge Clock) begin
    if (!Reset) begin
      rises = 0; hi_run = 0; lo_run = 0; seen_e = 1'b0; e_prev = 1'b0; valid_prev = 1'b0;
    end else begin
      check("bus_contention", 32'(oData_OE & (oLCD_RW | oLCD_E)), 32'd0);
      check("busy_vs_oe", 32'(oBusy), 32'(!oData_OE));
      if (oLCD_RW && exp_q.size() != 0) check("rs_hold", 32'(oLCD_RS), 32'(exp_q[0].rs));
      if (oLCD_E) begin
        if (!e_prev) begin
          rises = rises + 1;
          if (seen_e) check("e_low_width", 32'(lo_run >= int'(EN_LOW_CYCLES_DEF)), 32'd1);
          seen_e = 1'b1;
        end
        hi_run = hi_run + 1;
      end else begin
        if (e_prev) begin
          check("e_high_width", 32'(hi_run), 32'(EN_HIGH_CYCLES_DEF));
          hi_run = 0;
          lo_run = 0;
        end
        lo_run = lo_run + 1;
      end
      e_prev = oLCD_E;
      if (oValid) begin
        check("valid_single_pulse", 32'(valid_prev), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("byte", 32'(oByte), 32'(e.b));
          check("timeout", 32'(oTimeout), 32'(e.tmo));
          check("e_pulses", 32'(rises), 32'(2 * e.reads));
          check("latency", 32'(cyc - e.start_cyc), 32'(LAT_BASE - 2 + (e.reads - 1) * PAIR));
        end
        rises = 0;
        seen_e = 1'b0;
      end
      valid_prev = oValid;
    end
  end

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while ((oBusy || exp_q.size() != 0) && n < budget) begin
      @(posedge Clock);
      n = n + 1;
    end
    if (n >= budget) check("txn_done_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_txn(input logic rs, input logic poll, input bq_t seq);
    exp_t e;
    logic [7:0] b;
    logic t;
    int r;
    wait_quiet(4000);
    ref_model(rs, poll, seq, b, t, r);
    @(posedge Clock); #1;
    iRS = rs; iPollBusy = poll; iStart = 1'b1;
    @(posedge Clock); #1;
    iStart = 1'b0;
    iRS = 1'($urandom);
    iPollBusy = 1'($urandom);
    e.b = b; e.tmo = t; e.reads = r; e.rs = rs; e.start_cyc = cyc;
    nib_hi = 1'b1;
    lcd_q = seq;
    exp_q.push_back(e);
  endtask

  initial begin
    bq_t sq;
    int  n;

    repeat (3) @(posedge Clock);
    #1;
    check("rst_e", 32'(oLCD_E), 32'd0);
    check("rst_rs", 32'(oLCD_RS), 32'd0);
    check("rst_rw", 32'(oLCD_RW), 32'd0);
    check("rst_oe", 32'(oData_OE), 32'd1);
    check("rst_byte", 32'(oByte), 32'h00);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_timeout", 32'(oTimeout), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    #2 Reset = 1'b1;

    sq = {8'hA5};
    run_txn(1'b1, 1'b0, sq);
    sq = {8'h83, 8'h83, 8'h83, 8'h03};
    run_txn(1'b0, 1'b1, sq);
    sq = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_txn(1'b0, 1'b1, sq);

    // Second start lands in the high-nibble gap and must be dropped
    sq = {8'h3C};
    run_txn(1'b1, 1'b0, sq);
    repeat (40) @(posedge Clock);
    #1 iStart = 1'b1; iRS = 1'b0; iPollBusy = 1'b1;
    @(posedge Clock);
    #1 iStart = 1'b0;
    sq = {8'h5A};
    run_txn(1'b0, 1'b0, sq);

    // Asynchronous reset during the low-nibble enable pulse
    sq = {8'hC3};
    run_txn(1'b1, 1'b0, sq);
    n = 0;
    while (rises < 2 && n < 500) begin
      @(posedge Clock);
      n = n + 1;
    end
    check("reach_lo_e", 32'(rises >= 2), 32'd1);
    @(posedge Clock);
    #3 Reset = 1'b0;
    #1;
    check("arst_e", 32'(oLCD_E), 32'd0);
    check("arst_rw", 32'(oLCD_RW), 32'd0);
    check("arst_oe", 32'(oData_OE), 32'd1);
    check("arst_busy", 32'(oBusy), 32'd0);
    check("arst_valid", 32'(oValid), 32'd0);
    check("arst_byte", 32'(oByte), 32'h00);
    exp_q.delete();
    lcd_q.delete();
    nib_hi = 1'b1;
    repeat (3) @(posedge Clock);
    #2 Reset = 1'b1;
    sq = {8'h69};
    run_txn(1'b1, 1'b0, sq);

    for (int t = 0; t < 25; t++) begin
      bq_t s;
      logic rs, poll;
      int k;
      rs = 1'($urandom);
      poll = 1'($urandom);
      k = int'($urandom_range(0, 6));
      s = {};
      for (int i = 0; i < k; i++) s.push_back(8'h80 | 8'($urandom));
      s.push_back(8'($urandom) & 8'h7F);
      run_txn(rs, poll, s);
    end

    wait_quiet(4000);
    repeat (5) @(posedge Clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_reader.md
Name: lcd_reader

Overview:
- Read-side counterpart of the LCD nibble writer: executes HD44780 4-bit read cycles (RW=1) on the Spartan-3E character LCD.
- Returns either the busy-flag/address byte (RS=0) or a DDRAM/CGRAM data byte (RS=1).
- Optional busy-poll mode repeats busy-flag reads until BF=0, so the sequencer can replace fixed 40 us waits.
- Sits beside the writer; the top level muxes E/RS/nibble ownership and drives the DB[7:4] tristate from oData_OE.

Parameters:
- SETUP_CYCLES, 3, clocks RS/RW stable before E rises (tAS >= 40 ns at 50 MHz)
- EN_HIGH_CYCLES, 12, clocks E held high per nibble (PW_EH >= 230 ns, covers tDDR 160 ns)
- EN_LOW_CYCLES, 50, clocks E held low after each nibble (about 1 us; covers tcycE and hold)
- POLL_LIMIT, 1000, max busy-flag reads in poll mode before timeout

Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-low reset
- iStart  in  1  one-cycle request; sampled only in IDLE
- iRS  in  1  register select for the transaction; latched at start
- iPollBusy  in  1  1 = repeat RS=0 reads until bit7=0; latched at start; ignored when iRS=1
- iLCD_Data  in  4  DB[7:4] from the pad input buffer
- oLCD_E  out  1  LCD enable
- oLCD_RS  out  1  LCD register select
- oLCD_RW  out  1  LCD read/write (1 = read)
- oData_OE  out  1  FPGA drives DB[7:4] when 1; 0 for the whole read transaction
- oByte  out  8  assembled byte {high nibble, low nibble}; holds until the next oValid
- oValid  out  1  one-cycle pulse when oByte is updated
- oTimeout  out  1  qualifies oValid: poll limit exhausted with BF still 1
- oBusy  out  1  1 from the cycle after an accepted iStart until the return to IDLE

Behaviour:
- Reset (async, Reset=0) values: oLCD_E=0, oLCD_RS=0, oLCD_RW=0, oData_OE=1, oByte=8'h00, oValid=0, oTimeout=0, oBusy=0, state IDLE, counters 0.
- A reset mid-transaction aborts immediately and produces no oValid.
- All outputs are registered.
- Timer: one down-counter reloaded on every state entry. Poll counter: 10 bits minimum, sized by $clog2(POLL_LIMIT+1).
- IDLE: E=0, RW=0, OE=1. On iStart, latch iRS/iPollBusy, clear poll count, go to SETUP.
- SETUP: RW=1, OE=0, RS=latched value, E=0 for SETUP_CYCLES.
- HI_E: E=1 for EN_HIGH_CYCLES. On the final cycle (the edge where E falls), capture iLCD_Data into the high nibble.
- HI_GAP: E=0 for EN_LOW_CYCLES.
- LO_E: E=1 for EN_HIGH_CYCLES; capture the low nibble on the final cycle.
- LO_GAP: E=0 for EN_LOW_CYCLES. At exit, assemble the byte and evaluate:
  - Not polling, or iRS=1: go to DONE.
  - Polling and bit7=0: go to DONE.
  - Polling, bit7=1, poll count+1 < POLL_LIMIT: increment count, go to HI_E. RW stays 1, OE stays 0, no new setup.
  - Otherwise: go to DONE with the timeout flag set.
- DONE (1 cycle): oByte <= assembled byte, oValid=1, oTimeout=flag, RW=0, OE stays 0. Next cycle: IDLE with OE=1.
  - The bus is released one cycle before RW drops and reclaimed one cycle after, avoiding contention.
- oBusy is high from SETUP through DONE inclusive.
- iStart while oBusy=1 is ignored; there is no queueing.
- Non-poll latency, iStart to oValid: 1 + SETUP + 2*(EN_HIGH + EN_LOW) + 1 = 129 clocks at the defaults.
- Each extra poll iteration adds 2*(EN_HIGH+EN_LOW) = 124 clocks.
- POLL_LIMIT counts total reads, including the first.
- iLCD_Data is sampled only on the two capture edges; changes at any other time have no effect.

Decomposition:
- lcd_pkg: state encoding (IDLE, SETUP, HI_E, HI_GAP, LO_E, LO_GAP, DONE), RS_INSTR=0 / RS_DATA=1, the BF bit index (7), and the default timing constants shared with the writer.
- One natural sub-module: lcd_phase_timer (loadable down-counter with a done flag), also reusable by the writer.

Test Plan:
- Data read: iRS=1, model drives 4'hA during the first E-high and 4'h5 during the second. Expect oByte=8'hA5, one oValid at clock 129, oTimeout=0, RS=1 throughout, OE=0 before the first E rise.
- Busy poll: iRS=0, iPollBusy=1, model returns BF=1 (byte 8'h83) for 3 reads, then 8'h03. Expect exactly 4 E-pulse pairs, a single oValid with oByte=8'h03, oTimeout=0.
- Timeout: POLL_LIMIT=4, model always returns 8'hFF. Expect exactly 4 read pairs, then oValid=1 with oTimeout=1 and oByte=8'hFF.
- Bus turnaround: check each cycle that OE=1 never coincides with RW=1 or E=1, and that E high width is 12 and E low width is >= 50 clocks.
- Start while busy: pulse iStart again in HI_GAP. Expect no second transaction and exactly one oValid; a subsequent iStart in IDLE works.
- Async reset mid-LO_E: drop Reset without a clock edge. Expect E=0, RW=0, OE=1, oBusy=0 immediately, no oValid, oByte=8'h00; after release, a fresh read returns the correct byte.
